// File: rtl/serial_add_sequencer.sv
// ---------------------------------------------------------------------------
// serial_add_sequencer
//   Bit-serial add/subtract sequencer that drives an external single-bit full
//   adder, LSB first, one bit per enabled cycle. Assembles a WIDTH-bit result,
//   the final carry (no-borrow for subtract) and the signed-overflow flag,
//   then shows done for one enabled cycle.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   ena                clock enable; all state holds while low
//   start              request, honoured only in IDLE
//   op_a, op_b, sub    operands and operation (0 = A+B, 1 = A-B)
//   fa_a/fa_b/fa_cin   drive to the full adder (0 outside SHIFT)
//   fa_sum/fa_cout     full-adder outputs, valid in the same cycle
//   busy, done         SHIFT / DONE state indicators
//   result, carry_out,
//   overflow           operation results, held until the next accepted start
// ---------------------------------------------------------------------------
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_sr_q,      a_sr_d;
  logic [WIDTH-1:0] b_sr_q,      b_sr_d;
  logic             sub_q,       sub_d;
  logic             carry_q,     carry_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q,  overflow_d;

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sr_d   = op_a;
            b_sr_d   = op_b;
            sub_d    = sub;
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            carry_d  = sub;
            cnt_d    = '0;
            result_d = '0;
            state_d  = S_SHIFT;
          end
        end
        S_SHIFT: begin
          result_d = {fa_sum, result_q[WIDTH-1:1]};
          carry_d  = fa_cout;
          a_sr_d   = a_sr_q >> 1;
          b_sr_d   = b_sr_q >> 1;
          if (cnt_q == CNT_LAST) begin
            // MSB step: overflow is carry-in xor carry-out of the sign bit.
            carry_out_d = fa_cout;
            overflow_d  = carry_q ^ fa_cout;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

  // Full-adder drive is combinational so the adder answers in the same cycle.
  assign fa_a   = busy & a_sr_q[0];
  assign fa_b   = busy & (b_sr_q[0] ^ sub_q);
  assign fa_cin = busy & carry_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
module tb_serial_add_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, ena, start, sub;
  logic [W-1:0] op_a, op_b;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow)
  );

  // Behavioural single-bit full adder cell.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the captured operands.
  function automatic int to_signed(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, b, input logic s);
    int r;
    r = s ? int'(a) - int'(b) : int'(a) + int'(b);
    return W'(r);
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] a, b, input logic s);
    return s ? (int'(a) >= int'(b)) : (int'(a) + int'(b) >= (1 << W));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic s);
    int r;
    r = s ? to_signed(a) - to_signed(b) : to_signed(a) + to_signed(b);
    return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endfunction

  // Carry (no-borrow for subtract) flowing into bit i: compare low i bits.
  function automatic logic ref_cin(input logic [W-1:0] a, b, input logic s, input int i);
    int m, am, bm;
    m  = 1 << i;
    am = int'(a) % m;
    bm = int'(b) % m;
    return s ? (am >= bm) : (am + bm >= m);
  endfunction

  task automatic run_op(input logic [W-1:0] a, b, input logic s,
                        input int stall_at, input int stall_len,
                        input int hold_done, input bit spam);
    int bi, cyc;
    op_a = a; op_b = b; sub = s; start = 1'b1; ena = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    bi = 0; cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      ena = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (spam) begin
        start = 1'b1; op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
      end
      if (bi < W) begin
        chk("fa_a", fa_a, a[bi]);
        chk("fa_b", fa_b, b[bi] ^ s);
        chk("fa_cin", fa_cin, ref_cin(a, b, s, bi));
      end
      tick();
      cyc++;
      if (ena) bi++;
    end
    start = 1'b0; ena = 1'b1;
    chk("latency", cyc, W + stall_len);
    chk("done_high", done, 1);
    chk("busy_in_done", busy, 0);
    chk("result", result, ref_result(a, b, s));
    chk("carry_out", carry_out, ref_carry(a, b, s));
    chk("overflow", overflow, ref_ovf(a, b, s));
    for (int k = 0; k < hold_done; k++) begin
      ena = 1'b0;
      tick();
      chk("done_held", done, 1);
      chk("result_held_stall", result, ref_result(a, b, s));
    end
    ena = 1'b1;
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("result_held_idle", result, ref_result(a, b, s));
    chk("fa_a_idle", fa_a, 0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);

    // Directed cases.
    run_op(8'h5A, 8'h3C, 1'b0, 99, 0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 99, 0, 0, 1'b0);
    run_op(8'h10, 8'h20, 1'b1, 99, 0, 0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 99, 0, 0, 1'b0);
    run_op(8'h5A, 8'h3C, 1'b0, 3, 3, 2, 1'b0);   // stall mid-SHIFT, hold in DONE
    run_op(8'h5A, 8'h3C, 1'b0, 99, 0, 0, 1'b1);  // start spam while busy

    // Reset at bit 4 of an add: operation discarded, no done.
    op_a = 8'h5A; op_b = 8'h3C; sub = 1'b0; start = 1'b1; ena = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {carry_out, overflow}, 0);
    chk("midrst_fa", {fa_a, fa_b, fa_cin}, 0);
    for (int k = 0; k < W + 2; k++) begin
      tick();
      chk("no_done_after_rst", done, 0);
    end
    run_op(8'h5A, 8'h3C, 1'b0, 99, 0, 0, 1'b0);

    // Randomized operations with random stalls, DONE holds and start spam.
    for (int n = 0; n < 24; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, W - 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Bit-serial add/subtract sequencer wrapped around the single-bit full-adder cell. It accepts two WIDTH-bit operands on a start strobe and drives the full adder one bit per enabled cycle, LSB first. Each cycle it feeds the adder's a/b/cin inputs and consumes its sum/cout outputs. It assembles the WIDTH-bit result, final carry and signed-overflow flag, then pulses done.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- ena  in  1  clock enable; when 0 all state holds (including done)
- start  in  1  request; sampled only in IDLE with ena=1
- op_a  in  WIDTH  operand A, captured on accepted start
- op_b  in  WIDTH  operand B, captured on accepted start
- sub  in  1  0 = A+B, 1 = A−B (two's complement), captured on accepted start
- fa_a  out  1  to full adder a
- fa_b  out  1  to full adder b
- fa_cin  out  1  to full adder cin
- fa_sum  in  1  from full adder sum
- fa_cout  in  1  from full adder cout
- busy  out  1  high in SHIFT
- done  out  1  high in DONE
- result  out  WIDTH  sum/difference; valid while done=1, held until next accepted start
- carry_out  out  1  final carry (for subtract: 1 = no borrow)
- overflow  out  1  signed overflow of the operation

## Operation
- State machine: IDLE → SHIFT → DONE → IDLE. All transitions require ena=1.
- IDLE, start=1:
  - Load a_sr←op_a, b_sr←op_b, sub_r←sub, carry_r←sub, cnt←0, result←0.
  - Go to SHIFT.
- SHIFT, combinational drive:
  - fa_a=a_sr[0], fa_b=b_sr[0]^sub_r, fa_cin=carry_r.
  - The full adder is combinational; fa_sum/fa_cout are valid in the same cycle.
- SHIFT, each enabled edge:
  - result←{fa_sum, result[WIDTH-1:1]}; carry_r←fa_cout.
  - a_sr, b_sr shift right by 1; cnt←cnt+1.
- SHIFT, edge where cnt=WIDTH−1:
  - Additionally carry_out←fa_cout and overflow←carry_r^fa_cout (carry into MSB xor carry out of MSB).
  - Go to DONE.
- DONE: next enabled edge → IDLE. result, carry_out and overflow are held.
- fa_a/fa_b/fa_cin are driven 0 outside SHIFT.
- start outside IDLE is ignored: no queuing, no effect on the operation in flight.
- cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH−1.
- rst_n=0 at any edge, including mid-SHIFT:
  - State←IDLE; all outputs and registers←0.
  - The operation in flight is discarded; no done pulse.

## Timing
- Reset value of every output: busy=0, done=0, result=0, carry_out=0, overflow=0, fa_a=fa_b=fa_cin=0.
- Start accepted at enabled edge E0; busy=1 immediately after E0.
- Bit i (LSB first) is processed at the (i+1)th enabled edge after E0.
- After the WIDTH-th enabled edge: busy=0, done=1, results valid.
- With ena held high, latency start→done is WIDTH cycles; done is high for exactly 1 cycle.
- Earliest next start is accepted at the edge after the one where done drops: IDLE sample, so the back-to-back period is WIDTH+2 cycles.
- ena=0 stretches any state by exactly the number of disabled cycles; done stays high while ena=0 in DONE.

## Test plan
- Add, WIDTH=8, ena=1: A=0x5A, B=0x3C, sub=0 → done 8 cycles after start; result=0x96, carry_out=0, overflow=1.
- Add carry wrap: A=0xFF, B=0x01 → result=0x00, carry_out=1, overflow=0; fa_cin observed 1 on bits 1–7.
- Subtract: A=0x10, B=0x20, sub=1 → result=0xF0, carry_out=0, overflow=0. Then A=0x80, B=0x01 → result=0x7F, carry_out=1, overflow=1.
- ena gating: A=0x5A, B=0x3C with ena=0 for 3 cycles mid-SHIFT → done arrives 11 cycles after start; result still 0x96. Hold ena=0 during DONE → done stays 1.
- start asserted every cycle while busy with different operands → ignored; first result unchanged. Next op accepted only from IDLE.
- rst_n=0 for one edge at bit 4 of an add → next cycle all outputs 0, state IDLE, no done. A subsequent start completes normally.
